program_counter_mips_ras: RTL and testbench
===========================================

// Module: program_counter_mips_ras
// PURPOSE
//  Parametrised MIPS fetch program counter: successor to the basic PC. Adds conditional
//  PC-relative branch, register jump, stall, and a return-address stack (RAS) for
//  call/return. Sits at the head of the fetch stage and drives the instruction memory address.
//  Single clock; no delay slot (return address = ptr + STEP).
// PARAMETERS
//  ADDR_WIDTH  32            PC width in bits; must be >= 29
//  RESET_ADDR  32'h0000_0000 value loaded into ptr on reset (truncated to ADDR_WIDTH)
//  STEP        4             sequential increment in bytes
//  RAS_DEPTH   4             RAS entries; power of two, >= 2
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous reset, active-high
//  instruction  in   32          current instruction; [25:0] jump index, [15:0] branch offset
//  stall        in   1           hold PC and RAS this cycle
//  is_jump      in   1           J: absolute jump
//  is_jal       in   1           JAL: absolute jump and push return address
//  is_branch    in   1           conditional branch instruction
//  branch_taken in   1           branch condition result; qualifies is_branch
//  is_jr        in   1           JR: jump to jr_target, RAS untouched
//  is_ret       in   1           return: pop RAS, jump to popped value
//  jr_target    in   ADDR_WIDTH  register value for is_jr, and is_ret fallback
//  ptr          out  ADDR_WIDTH  current PC (registered)
//  ras_count    out  clog2(RAS_DEPTH)+1  valid RAS entries
//  ras_empty    out  1           ras_count == 0
//  ras_full     out  1           ras_count == RAS_DEPTH
//  ras_overflow out  1           sticky: push occurred while full; cleared only by reset
// BEHAVIOUR
//  - Reset (sync): ptr=RESET_ADDR; ras_count=0; ras_empty=1; ras_full=0; ras_overflow=0;
//    RAS contents don't-care. Reset overrides every other input.
//  - All updates on rising clk. ptr changes one cycle after the controls are sampled.
//  - Priority, highest first: reset > stall > is_ret > is_jr > is_jal > is_jump >
//    (is_branch & branch_taken) > sequential. Only the winner acts. Losers have no side
//    effect (no push or pop).
//  - stall: ptr and all RAS state hold.
//  - seq = ptr + STEP, modulo 2^ADDR_WIDTH (wraps at the top, no flag).
//  - is_jump / is_jal target: {seq[ADDR_WIDTH-1:28], instruction[25:0], 2'b00}.
//  - is_jal also pushes seq onto the RAS.
//  - Branch target: seq + (sign_extend(instruction[15:0]) << 2), mod 2^ADDR_WIDTH.
//  - is_branch & !branch_taken: sequential.
//  - is_jr: ptr <= jr_target.
//  - is_ret:
//      RAS non-empty: ptr <= top entry, then pop (ras_count - 1).
//      RAS empty: ptr <= jr_target; count stays 0; no flag.
//  - RAS is circular, top-of-stack pointer wraps mod RAS_DEPTH.
//      Push when full: overwrite the oldest entry; count stays RAS_DEPTH; set ras_overflow.
//      Pop after overflow returns the newest RAS_DEPTH return addresses in LIFO order.
//  - ras_empty and ras_full are derived from the registered count (no extra latency).
// TESTING
//  1. reset=1 for one edge, then 3 free-running edges -> ptr 0x0, 0x4, 0x8, 0xC; ras_empty=1.
//  2. ptr=0x8, is_jump=1, instruction=32'h0AAA_AAAA -> next ptr=0x0AAA_AAA8.
//  3. ptr=0x10, is_branch=1, instruction[15:0]=16'hFFFC:
//       branch_taken=1 -> ptr=0x04; branch_taken=0 -> ptr=0x14.
//  4. ptr=0x100, is_jal=1, instr[25:0]=26'h40 -> ptr=0x100, ras_count=1.
//     Then is_ret=1 -> ptr=0x104, ras_empty=1.
//     is_ret again with jr_target=0x2000 -> ptr=0x2000.
//  5. RAS_DEPTH=4: 5 JALs from ptr 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_full=1, ras_overflow=1.
//     5 rets -> ptr 0x44, 0x34, 0x24, 0x14, then jr_target (empty).
//  6. Corner cases:
//       stall=1 with is_jal=1 -> ptr and ras_count unchanged.
//       is_ret & is_jump together -> ret wins.
//       reset mid-sequence with RAS full -> ptr=RESET_ADDR, count=0, overflow=0 next cycle.
//       ptr=0xFFFF_FFFC sequential -> ptr=0x0.

Source files
------------

// File: rtl/program_counter_mips_ras.sv
// MIPS fetch program counter with conditional branch, register jump, stall and a
// circular return-address stack for call/return prediction.
module program_counter_mips_ras #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          STEP       = 4,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instruction,
    input  logic                        stall,
    input  logic                        is_jump,
    input  logic                        is_jal,
    input  logic                        is_branch,
    input  logic                        branch_taken,
    input  logic                        is_jr,
    input  logic                        is_ret,
    input  logic [ADDR_WIDTH-1:0]       jr_target,
    output logic [ADDR_WIDTH-1:0]       ptr,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ras_overflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] RST_PTR = ADDR_WIDTH'(RESET_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(STEP);
    localparam logic [CW-1:0]         DEPTH_C = CW'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] seq, jump_tgt, br_tgt;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]         top_q, top_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  push;
    logic                  full;
    logic                  unused_instr;

    assign seq      = ptr_q + STEP_C;
    assign jump_tgt = {seq[ADDR_WIDTH-1:28], instruction[25:0], 2'b00};
    assign br_tgt   = seq + {{(ADDR_WIDTH-18){instruction[15]}}, instruction[15:0], 2'b00};
    assign full     = (count_q == DEPTH_C);
    assign unused_instr = ^instruction[31:26];

    always_comb begin
        ptr_d   = ptr_q;
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        if (!stall) begin
            if (is_ret) begin
                // An empty stack falls back to the register target without flagging.
                if (count_q != '0) begin
                    ptr_d   = ras_q[top_q];
                    top_d   = top_q - 1'b1;
                    count_d = count_q - 1'b1;
                end else begin
                    ptr_d = jr_target;
                end
            end else if (is_jr) begin
                ptr_d = jr_target;
            end else if (is_jal) begin
                ptr_d = jump_tgt;
                push  = 1'b1;
                top_d = top_q + 1'b1;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (is_jump) begin
                ptr_d = jump_tgt;
            end else if (is_branch && branch_taken) begin
                ptr_d = br_tgt;
            end else begin
                ptr_d = seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= RST_PTR;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Stack storage carries no reset; when full the new top lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            ras_q[top_d] <= seq;
        end
    end

    assign ptr          = ptr_q;
    assign ras_count    = count_q;
    assign ras_empty    = (count_q == '0);
    assign ras_full     = full;
    assign ras_overflow = ovf_q;

endmodule

// File: tb/tb_program_counter_mips_ras.sv
// Bench for program_counter_mips_ras: directed scenarios plus randomized control
// traffic, checked against a queue-based reference model.
module tb_program_counter_mips_ras;

    logic        clk = 1'b0;
    logic        reset, stall, is_jump, is_jal, is_branch, branch_taken, is_jr, is_ret;
    logic [31:0] instruction, jr_target, ptr;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_overflow;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_ptr;
    logic [31:0] m_q [$];
    bit          m_ovf;

    program_counter_mips_ras dut (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall),
        .is_jump(is_jump), .is_jal(is_jal), .is_branch(is_branch),
        .branch_taken(branch_taken), .is_jr(is_jr), .is_ret(is_ret),
        .jr_target(jr_target), .ptr(ptr), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: next state straight from the priority rules; the stack is a queue
    // whose front is the oldest return address.
    task automatic model_update();
        logic [31:0] seq, jtgt;
        seq  = m_ptr + 32'd4;
        jtgt = (seq & 32'hF000_0000) | (32'(instruction[25:0]) << 2);
        if (reset) begin
            m_ptr = 32'h0;
            m_q.delete();
            m_ovf = 0;
        end else if (stall) begin
        end else if (is_ret) begin
            if (m_q.size() > 0) m_ptr = m_q.pop_back();
            else                m_ptr = jr_target;
        end else if (is_jr) begin
            m_ptr = jr_target;
        end else if (is_jal) begin
            m_q.push_back(seq);
            if (m_q.size() > 4) begin
                void'(m_q.pop_front());
                m_ovf = 1;
            end
            m_ptr = jtgt;
        end else if (is_jump) begin
            m_ptr = jtgt;
        end else if (is_branch && branch_taken) begin
            m_ptr = seq + 32'($signed(instruction[15:0]) * 4);
        end else begin
            m_ptr = seq;
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic j, input logic jal,
                        input logic br, input logic bt, input logic jr, input logic ret,
                        input logic [31:0] instr, input logic [31:0] jrt);
        reset = rst; stall = stl; is_jump = j; is_jal = jal; is_branch = br;
        branch_taken = bt; is_jr = jr; is_ret = ret; instruction = instr; jr_target = jrt;
        @(posedge clk);
        #1;
        model_update();
        chk("ptr",      64'(ptr),          64'(m_ptr));
        chk("count",    64'(ras_count),    64'(m_q.size()));
        chk("empty",    64'(ras_empty),    64'(m_q.size() == 0));
        chk("full",     64'(ras_full),     64'(m_q.size() == 4));
        chk("overflow", 64'(ras_overflow), 64'(m_ovf));
    endtask

    task automatic seq_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic jr_to(input logic [31:0] t);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0, t);
    endtask

    logic [31:0] saved_ptr;
    logic [2:0]  saved_cnt;

    initial begin
        m_ptr = 32'h0;
        m_ovf = 0;

        // Reset then free-running
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("rst_ptr", 64'(ptr), 64'h0);
        chk("rst_empty", 64'(ras_empty), 64'h1);
        seq_step(); chk("seq1", 64'(ptr), 64'h4);
        seq_step(); chk("seq2", 64'(ptr), 64'h8);
        seq_step(); chk("seq3", 64'(ptr), 64'hC);
        chk("seq_empty", 64'(ras_empty), 64'h1);

        // Absolute jump
        jr_to(32'h8);
        step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0AAA_AAAA, 32'h0);
        chk("jump", 64'(ptr), 64'h0AAA_AAA8);

        // Branch taken / not taken
        jr_to(32'h10);
        step(0, 0, 0, 0, 1, 1, 0, 0, 32'h0000_FFFC, 32'h0);
        chk("br_taken", 64'(ptr), 64'h4);
        jr_to(32'h10);
        step(0, 0, 0, 0, 1, 0, 0, 0, 32'h0000_FFFC, 32'h0);
        chk("br_not_taken", 64'(ptr), 64'h14);

        // Call / return / empty return
        jr_to(32'h100);
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0040, 32'h0);
        chk("jal_ptr", 64'(ptr), 64'h100);
        chk("jal_cnt", 64'(ras_count), 64'h1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        chk("ret_ptr", 64'(ptr), 64'h104);
        chk("ret_empty", 64'(ras_empty), 64'h1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h2000);
        chk("ret_fallback", 64'(ptr), 64'h2000);

        // Overflow: five calls into a four-deep stack
        jr_to(32'h0);
        for (int k = 0; k < 5; k++)
            step(0, 0, 0, 1, 0, 0, 0, 0, 32'((k + 1) * 4), 32'h0);
        chk("ovf_full", 64'(ras_full), 64'h1);
        chk("ovf_flag", 64'(ras_overflow), 64'h1);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h3000);
            chk("ovf_ret", 64'(ptr), (k < 4) ? 64'(32'h44 - 32'(k) * 32'h10) : 64'h3000);
        end

        // Stall with jal
        saved_ptr = ptr;
        saved_cnt = ras_count;
        step(0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0100, 32'h0);
        chk("stall_ptr", 64'(ptr), 64'(saved_ptr));
        chk("stall_cnt", 64'(ras_count), 64'(saved_cnt));

        // ret beats jump
        jr_to(32'h200);
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0300, 32'h0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 32'h0000_0500, 32'h0);
        chk("ret_over_jump", 64'(ptr), 64'h204);

        // Reset mid-sequence with a full, overflowed stack
        for (int k = 0; k < 5; k++)
            step(0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0400 + 32'(k), 32'h0);
        chk("pre_rst_full", 64'(ras_full), 64'h1);
        step(1, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0400, 32'h0);
        chk("mid_rst_ptr", 64'(ptr), 64'h0);
        chk("mid_rst_cnt", 64'(ras_count), 64'h0);
        chk("mid_rst_ovf", 64'(ras_overflow), 64'h0);

        // Address wrap
        jr_to(32'hFFFF_FFFC);
        seq_step();
        chk("wrap", 64'(ptr), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 1'($urandom),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
